// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: FSM state
// encodings, 8N1 framing constants and a counter-width helper.
package fifo_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each period with tick. clear holds the count at zero.
module baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             tick_r;

  // Next count: wrap only at the terminal count, hold zero while cleared.
  always_comb begin
    cnt_next_s = cnt_r;
    if (clear) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // Counter and registered terminal-count flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      tick_r <= (cnt_next_s == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a first-word-fall-through FIFO and sends each one as
// DATA_WIDTH/8 UART bytes (8N1), least-significant byte first.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rpull,
  output logic                  txd,
  output logic                  busy
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BYTE_W = idx_width(BYTES);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  state_t              state_r, state_next_s;
  logic [DATA_WIDTH-1:0] word_r, word_next_s;
  logic [2:0]          bit_idx_r, bit_idx_next_s;
  logic [BYTE_W-1:0]   byte_idx_r, byte_idx_next_s;
  logic                txd_r, txd_next_s;
  logic                busy_r;
  logic                tick_s;
  logic                rpull_s;

  assign rpull_s = (state_r == ST_IDLE) & enable & ~rempty & ~rst;

  // The counter sits at zero in IDLE so the first START cycle begins a full period.
  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (state_r == ST_IDLE),
    .tick  (tick_s)
  );

  // Next-state logic; the word register shifts right so txd always reads bit 0.
  always_comb begin
    state_next_s    = state_r;
    word_next_s     = word_r;
    bit_idx_next_s  = bit_idx_r;
    byte_idx_next_s = byte_idx_r;
    case (state_r)
      ST_IDLE: begin
        if (rpull_s) begin
          state_next_s    = ST_START;
          word_next_s     = rdata;
          bit_idx_next_s  = 3'd0;
          byte_idx_next_s = {BYTE_W{1'b0}};
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_next_s   = ST_DATA;
          bit_idx_next_s = 3'd0;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          word_next_s = {1'b0, word_r[DATA_WIDTH-1:1]};
          if (bit_idx_r == LAST_BIT) begin
            state_next_s = ST_STOP;
          end else begin
            bit_idx_next_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          if (byte_idx_r != LAST_BYTE) begin
            byte_idx_next_s = byte_idx_r + BYTE_W'(1);
            state_next_s    = ST_START;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Line level for the state being entered, so txd changes on that same edge.
  always_comb begin
    txd_next_s = UART_IDLE_LEVEL;
    case (state_next_s)
      ST_IDLE:  txd_next_s = UART_IDLE_LEVEL;
      ST_START: txd_next_s = ~UART_IDLE_LEVEL;
      ST_DATA:  txd_next_s = word_next_s[0];
      ST_STOP:  txd_next_s = UART_IDLE_LEVEL;
      default:  txd_next_s = UART_IDLE_LEVEL;
    endcase
  end

  // State, datapath and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      word_r     <= {DATA_WIDTH{1'b0}};
      bit_idx_r  <= 3'd0;
      byte_idx_r <= {BYTE_W{1'b0}};
      txd_r      <= UART_IDLE_LEVEL;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      word_r     <= word_next_s;
      bit_idx_r  <= bit_idx_next_s;
      byte_idx_r <= byte_idx_next_s;
      txd_r      <= txd_next_s;
      busy_r     <= (state_next_s != ST_IDLE);
    end
  end

  assign rpull = rpull_s;
  assign txd   = txd_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: a FIFO model feeds the DUT, each pop pushes the word it
// hands over, and a serial receiver decodes txd and compares against it.
module tb_fifo_uart_tx;

  localparam int DW       = 32;
  localparam int N        = 4;
  localparam int BYTES    = DW / 8;
  localparam int BYTE_CYC = 10 * N;
  localparam int WORD_CYC = BYTES * BYTE_CYC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rpull, txd, busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_mem [0:63];
  int            rd_ptr = 0;
  int            wr_ptr = 0;
  logic [DW-1:0] exp_q [$];

  int            rpull_total = 0;
  int            busy_run = 0;
  int            gap_cnt = 0;
  int            last_gap = -1;
  logic          prev_busy = 1'b0;
  logic          prev_rpull = 1'b0;
  logic          rx_active = 1'b0;
  int            rx_cyc = 0;
  logic [DW-1:0] rx_word = '0;

  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = fifo_mem[rd_ptr[5:0]];

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .rempty (rempty),
    .rdata  (rdata),
    .rpull  (rpull),
    .txd    (txd),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // FIFO read side: a pop hands the head word to the scoreboard.
  always @(posedge clk) begin
    if (rpull === 1'b1) begin
      exp_q.push_back(fifo_mem[rd_ptr[5:0]]);
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor: protocol checks plus an 8N1 receiver sampling mid-bit.
  initial begin
    int o, k, b;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rpull_in_rst", rpull, 1'b0);
        rx_active = 1'b0;
        exp_q.delete();
        busy_run = 0;
        gap_cnt = 0;
        prev_busy = 1'b0;
        prev_rpull = 1'b0;
      end else begin
        if (rpull) rpull_total++;
        if (rpull && prev_rpull) check("rpull_width", 32'd2, 32'd1);
        if (!busy) check("idle_txd", txd, 1'b1);
        if (busy) busy_run++;
        if (!busy && prev_busy) begin
          check("busy_len", busy_run, WORD_CYC);
          busy_run = 0;
        end
        if (busy && !prev_busy) begin
          last_gap = gap_cnt;
          gap_cnt = 0;
        end else if (!busy) begin
          gap_cnt++;
        end
        if (!rx_active && txd == 1'b0) begin
          rx_active = 1'b1;
          rx_cyc = 0;
          rx_word = '0;
        end
        if (rx_active) begin
          check("busy_in_frame", busy, 1'b1);
          o = rx_cyc % BYTE_CYC;
          k = rx_cyc / BYTE_CYC;
          b = o / N;
          if (o % N == N / 2) begin
            if (b == 0) begin
              check("start_bit", txd, 1'b0);
            end else if (b <= 8) begin
              rx_word[8*k + b - 1] = txd;
            end else begin
              check("stop_bit", txd, 1'b1);
              if (k == BYTES - 1) begin
                if (exp_q.size() == 0) begin
                  check("unexpected_word", rx_word, 32'hxxxxxxxx);
                end else begin
                  check("word_data", rx_word, exp_q.pop_front());
                end
              end
            end
          end
          if (rx_cyc == WORD_CYC - 1) rx_active = 1'b0;
          else rx_cyc++;
        end
        prev_busy = busy;
        prev_rpull = rpull;
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    fifo_mem[wr_ptr[5:0]] = w;
    wr_ptr++;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (!(rd_ptr == wr_ptr && !busy) && n < budget) begin
      cycles(1);
      n++;
    end
    check(name, (n < budget), 1'b1);
    cycles(2);
  endtask

  task automatic wait_busy(input string name, input int budget);
    int n = 0;
    while (!busy && n < budget) begin
      cycles(1);
      n++;
    end
    check(name, busy, 1'b1);
  endtask

  initial begin
    int base;
    // Reset held with data waiting.
    push_word(32'hA5C30F81);
    repeat (5) begin
      @(negedge clk);
      check("rst_txd", txd, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_rpull", rpull, 1'b0);
    end
    @(posedge clk);
    #1;
    base = rpull_total;
    rst = 1'b0;
    #1;
    check("first_pop", rpull, 1'b1);
    drain("drain_single", 400);
    check("single_pops", rpull_total - base, 32'd1);

    // Back-to-back words, single idle cycle between them.
    base = rpull_total;
    push_word(32'h00000001);
    push_word(32'hFFFFFFFF);
    drain("drain_b2b", 600);
    check("b2b_pops", rpull_total - base, 32'd2);
    check("b2b_gap", last_gap, 32'd1);

    // enable dropped mid-word.
    base = rpull_total;
    push_word(32'h12345678);
    push_word(32'h9ABCDEF0);
    wait_busy("en_start", 20);
    cycles(49);
    enable = 1'b0;
    cycles(200);
    check("en_pops", rpull_total - base, 32'd1);
    check("en_busy", busy, 1'b0);
    check("en_pending", rempty, 1'b0);
    enable = 1'b1;
    #1;
    check("en_pop_now", rpull, 1'b1);
    drain("drain_en", 400);

    // Reset during byte 2 data.
    base = rpull_total;
    push_word(32'hDEADBEEF);
    push_word(32'h0BADF00D);
    wait_busy("rst_start", 20);
    cycles(95);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    #1;
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_txd", txd, 1'b1);
    drain("drain_rst", 400);
    check("rst_pops", rpull_total - base, 32'd2);

    // Random words with enable toggling.
    for (int i = 0; i < 6; i++) begin
      push_word($urandom);
      repeat ($urandom_range(1, 120)) begin
        cycles(1);
        enable = ($urandom_range(0, 3) != 0);
      end
    end
    enable = 1'b1;
    drain("drain_rand", 3000);

    // Empty FIFO: nothing happens.
    base = rpull_total;
    cycles(100);
    check("empty_pops", rpull_total - base, 32'd0);
    check("empty_busy", busy, 1'b0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("rx_idle", rx_active, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
